amplitude_ramp_ctrl: RTL and testbench

Sequencer for the DDS amplitude setting. It accepts a target amplitude in millivolts over a valid/ready handshake and slews the `amplitude_mv` word seen by the amplitude-scaling stage toward that target. The slew is done in bounded steps at a programmable rate, so output level changes never produce an audible or visible jump on the DAC. It sits between the user-control front end (buttons/UART decode) and the amplitude-scaling datapath.

---
 rtl/amplitude_ramp_ctrl.sv | 140 ++++++++++++++
 tb/tb_amplitude_ramp_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/amplitude_ramp_ctrl.sv
// Slews the DDS amplitude word toward a handshaken target in bounded, timed steps.
// Build option AMP_ZC_SYNC_EN: each due step is held until the next zero_cross pulse.
module amplitude_ramp_ctrl #(
  parameter int unsigned AMP_W    = 11,
  parameter int unsigned AMP_MAX  = 1650,
  parameter int unsigned STEP_MV  = 10,
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_valid,
  output logic             set_ready,
  input  logic [AMP_W-1:0] set_amplitude_mv,
  input  logic             zero_cross,
  output logic [AMP_W-1:0] amplitude_mv,
  output logic             busy,
  output logic             done
);

  localparam int unsigned TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DIFF_W = AMP_W + 1;
  localparam logic [AMP_W-1:0]  AMP_MAX_C = AMP_W'(AMP_MAX);
  localparam logic [DIFF_W-1:0] STEP_C    = DIFF_W'(STEP_MV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

`ifdef AMP_ZC_SYNC_EN
  typedef enum logic [1:0] {S_IDLE, S_RAMP, S_ZC_WAIT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RAMP} state_t;
  logic unused_zero_cross;
  assign unused_zero_cross = zero_cross;
`endif

  state_t             state_q, state_d;
  logic [AMP_W-1:0]   amp_q, amp_d;
  logic [AMP_W-1:0]   target_q, target_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;

  logic [AMP_W-1:0]         req_clamped;
  logic signed [DIFF_W-1:0] diff;
  logic [DIFF_W-1:0]        mag;
  logic [DIFF_W-1:0]        step;
  logic [AMP_W-1:0]         amp_step;
  logic                     xfer;
  logic                     step_en;

  // Step magnitude is bounded by the remaining distance, so the target is never overshot.
  always_comb begin
    req_clamped = (set_amplitude_mv > AMP_MAX_C) ? AMP_MAX_C : set_amplitude_mv;
    diff        = $signed({1'b0, target_q}) - $signed({1'b0, amp_q});
    mag         = diff[DIFF_W-1] ? DIFF_W'(-diff) : DIFF_W'(diff);
    step        = (mag > STEP_C) ? STEP_C : mag;
    amp_step    = diff[DIFF_W-1] ? (amp_q - AMP_W'(step)) : (amp_q + AMP_W'(step));
    xfer        = set_valid && ready_q;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    amp_d    = amp_q;
    target_d = target_q;
    tick_d   = tick_q;
    done_d   = 1'b0;
    step_en  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          target_d = req_clamped;
          if (req_clamped != amp_q) begin
            state_d = S_RAMP;
            tick_d  = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RAMP: begin
        if (tick_q == TICK_LAST) begin
`ifdef AMP_ZC_SYNC_EN
          state_d = S_ZC_WAIT;
`else
          step_en = 1'b1;
`endif
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
`ifdef AMP_ZC_SYNC_EN
      S_ZC_WAIT: begin
        if (zero_cross) step_en = 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (step_en) begin
      amp_d  = amp_step;
      tick_d = '0;
      if (amp_step == target_q) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = S_RAMP;
      end
    end

    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      amp_q    <= '0;
      target_q <= '0;
      tick_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      amp_q    <= amp_d;
      target_q <= target_d;
      tick_q   <= tick_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign amplitude_mv = amp_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign set_ready    = ready_q;

endmodule

// File: tb/tb_amplitude_ramp_ctrl.sv
// Directed bench for amplitude_ramp_ctrl with STEP_MV=10, TICK_DIV=4.
module tb_amplitude_ramp_ctrl;

  localparam int unsigned AMP_W = 11;
  localparam int TICK = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             set_valid;
  logic             set_ready;
  logic [AMP_W-1:0] set_amplitude_mv;
  logic             zero_cross;
  logic [AMP_W-1:0] amplitude_mv;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;
  int exp_seq [0:63];

  amplitude_ramp_ctrl #(
    .AMP_W(AMP_W), .AMP_MAX(1650), .STEP_MV(10), .TICK_DIV(TICK)
  ) dut (
    .clk(clk), .rst(rst), .set_valid(set_valid), .set_ready(set_ready),
    .set_amplitude_mv(set_amplitude_mv), .zero_cross(zero_cross),
    .amplitude_mv(amplitude_mv), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one request for a single edge; returns just after that edge (edge k).
  task automatic send(input int v);
    set_valid        = 1'b1;
    set_amplitude_mv = AMP_W'(v);
    step_clk(1);
    set_valid        = 1'b0;
  endtask

  // Walk a ramp one step at a time against exp_seq[0..n-1].
  task automatic check_ramp(input string tag, input int start, input int n);
    int prev;
    prev = start;
    for (int i = 0; i < n; i++) begin
      step_clk(TICK - 1);
      chk($sformatf("%s_hold%0d", tag, i), 32'(amplitude_mv), 32'(prev));
      step_clk(1);
      chk($sformatf("%s_amp%0d", tag, i), 32'(amplitude_mv), 32'(exp_seq[i]));
      chk($sformatf("%s_done%0d", tag, i), 32'(done), (i == n - 1) ? 32'd1 : 32'd0);
      chk($sformatf("%s_busy%0d", tag, i), 32'(busy), (i == n - 1) ? 32'd0 : 32'd1);
      prev = exp_seq[i];
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; set_valid = 1'b0; zero_cross = 1'b0; set_amplitude_mv = '0;
    step_clk(2);
    chk("rst_amp", 32'(amplitude_mv), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ready", 32'(set_ready), 1);
    rst = 1'b0;
    step_clk(1);
    chk("post_rst_ready", 32'(set_ready), 1);
    chk("post_rst_busy", 32'(busy), 0);

`ifdef AMP_ZC_SYNC_EN
    // Ramp 0->20 with zero_cross at k+2, k+4, k+9, k+16.
    send(20);
    chk("zc_busy", 32'(busy), 1);
    step_clk(1); zero_cross = 1'b1;
    step_clk(1); zero_cross = 1'b0;
    step_clk(1); zero_cross = 1'b1;
    step_clk(1); zero_cross = 1'b0;
    chk("zc_k4_amp", 32'(amplitude_mv), 0);
    step_clk(4);
    chk("zc_k8_amp", 32'(amplitude_mv), 0);
    chk("zc_k8_busy", 32'(busy), 1);
    zero_cross = 1'b1;
    step_clk(1); zero_cross = 1'b0;
    chk("zc_k9_amp", 32'(amplitude_mv), 10);
    chk("zc_k9_busy", 32'(busy), 1);
    step_clk(4);
    chk("zc_k13_amp", 32'(amplitude_mv), 10);
    step_clk(2);
    chk("zc_k15_amp", 32'(amplitude_mv), 10);
    zero_cross = 1'b1;
    step_clk(1); zero_cross = 1'b0;
    chk("zc_fin_amp", 32'(amplitude_mv), 20);
    chk("zc_fin_done", 32'(done), 1);
    chk("zc_fin_busy", 32'(busy), 0);
    chk("zc_fin_ready", 32'(set_ready), 1);
`else
    // Ramp 0->100; zero_cross held high has no effect in this build.
    zero_cross = 1'b1;
    send(100);
    chk("up_busy0", 32'(busy), 1);
    chk("up_ready0", 32'(set_ready), 0);
    chk("up_amp0", 32'(amplitude_mv), 0);
    chk("up_done0", 32'(done), 0);
    for (int i = 0; i < 10; i++) exp_seq[i] = 10 * (i + 1);
    check_ramp("up", 0, 10);
    chk("up_ready_end", 32'(set_ready), 1);
    zero_cross = 1'b0;
    step_clk(1);
    chk("up_done_clr", 32'(done), 0);
    chk("up_amp_hold", 32'(amplitude_mv), 100);

    // Down-ramp 100->35 with a short final step.
    send(35);
    exp_seq[0] = 90; exp_seq[1] = 80; exp_seq[2] = 70; exp_seq[3] = 60;
    exp_seq[4] = 50; exp_seq[5] = 40; exp_seq[6] = 35;
    check_ramp("down", 100, 7);
    step_clk(1);
    chk("down_done_clr", 32'(done), 0);
    chk("down_amp_hold", 32'(amplitude_mv), 35);

    // Clamp: 2000 -> 1650, 162 steps from 35, last step is 5 mV.
    send(2000);
    step_clk(161 * TICK);
    chk("clamp_amp_pre", 32'(amplitude_mv), 1645);
    chk("clamp_busy_pre", 32'(busy), 1);
    step_clk(TICK);
    chk("clamp_amp", 32'(amplitude_mv), 1650);
    chk("clamp_done", 32'(done), 1);
    chk("clamp_busy", 32'(busy), 0);
    step_clk(3);
    chk("clamp_amp_hold", 32'(amplitude_mv), 1650);
    chk("clamp_done_clr", 32'(done), 0);

    // No-op request equal to current level.
    send(1650);
    chk("noop_done", 32'(done), 1);
    chk("noop_busy", 32'(busy), 0);
    chk("noop_ready", 32'(set_ready), 1);
    chk("noop_amp", 32'(amplitude_mv), 1650);
    step_clk(1);
    chk("noop_done_clr", 32'(done), 0);
    chk("noop_busy2", 32'(busy), 0);

    // Backpressure: 500 held on set_valid during a ramp to 100.
    rst = 1'b1; step_clk(1); rst = 1'b0; step_clk(1);
    send(100);
    set_valid = 1'b1; set_amplitude_mv = AMP_W'(500);
    step_clk(TICK);
    chk("bp_amp1", 32'(amplitude_mv), 10);
    chk("bp_ready1", 32'(set_ready), 0);
    step_clk(9 * TICK);
    chk("bp_amp_end", 32'(amplitude_mv), 100);
    chk("bp_done", 32'(done), 1);
    chk("bp_ready_end", 32'(set_ready), 1);
    step_clk(1);
    set_valid = 1'b0;
    chk("bp_xfer_busy", 32'(busy), 1);
    chk("bp_xfer_ready", 32'(set_ready), 0);
    chk("bp_xfer_done", 32'(done), 0);
    step_clk(TICK);
    chk("bp_amp_110", 32'(amplitude_mv), 110);
    step_clk(39 * TICK);
    chk("bp_amp_500", 32'(amplitude_mv), 500);
    chk("bp_done_500", 32'(done), 1);

    // Reset mid-ramp: rst sampled at k+14.
    rst = 1'b1; step_clk(1); rst = 1'b0; step_clk(1);
    send(100);
    step_clk(13);
    chk("mid_amp_k13", 32'(amplitude_mv), 30);
    rst = 1'b1;
    step_clk(1);
    chk("mid_rst_amp", 32'(amplitude_mv), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    rst = 1'b0;
    step_clk(1);
    chk("mid_ready", 32'(set_ready), 1);
    chk("mid_busy", 32'(busy), 0);
    step_clk(2 * TICK);
    chk("mid_amp_stay", 32'(amplitude_mv), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
